axis_frame_skid_buffer: RTL and testbench
=========================================

AXIS_FRAME_SKID_BUFFER -- requirements
Module: axis_frame_skid_buffer

Interface
REQ-001 SHALL have parameter SKID_DATA_WIDTH, default 16, payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 2, buffer entries (power of two, >= 2).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports s_valid in 1, s_data in SKID_DATA_WIDTH, s_ready out 1: AXI-Stream slave.
REQ-006 SHALL have ports m_valid out 1, m_data out SKID_DATA_WIDTH, m_last out 1, m_ready in 1: AXI-Stream master.
REQ-007 SHALL have ports config_n in 4, config_valid in 1, config_ready out 1: frame-size config, frame length = 2^config_n samples.
REQ-008 SHALL have outputs n_out 4, total_samples 16, level $clog2(DEPTH)+1 (entries held), frame_done 1 (one-cycle pulse).

Function
REQ-009 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE.
REQ-010 IDLE: config_ready=1, s_ready=0; config_valid high captures config_n into n_out and moves to RUN next cycle.
REQ-011 total_samples SHALL equal 1 << n_out, 16-bit; n=0 gives 1, n=15 gives 32768.
REQ-012 RUN: config_ready=0; s_ready = (level < DEPTH) && (in_count < total_samples); s_ready SHALL NOT depend combinationally on m_ready.
REQ-013 Push on s_valid && s_ready; in_count increments per push; on reaching total_samples, FSM moves to DRAIN.
REQ-014 DRAIN: s_ready=0, config_ready=0; buffer empties via master port.
REQ-015 Buffer SHALL be FIFO-ordered; sample accepted at cycle t into an empty buffer SHALL appear on m_valid/m_data at t+1 (registered output).
REQ-016 Pop on m_valid && m_ready; simultaneous push and pop SHALL leave level unchanged and sustain one sample per cycle.
REQ-017 m_valid SHALL stay high and m_data/m_last stable while m_ready=0 (AXI hold rule).
REQ-018 m_last SHALL be 1 only with the sample whose out_count index equals total_samples-1.
REQ-019 On the pop of the m_last sample, frame_done SHALL pulse 1 for one cycle, counters clear, FSM returns to IDLE; config_ready is 1 the following cycle.
REQ-020 When level = DEPTH, s_ready SHALL be 0 even if m_ready=1 (no pass-through when full).
REQ-021 s_valid in IDLE or DRAIN SHALL be ignored; no data stored.
REQ-022 in_count and out_count SHALL be 17-bit internally so 2^15 is representable without wrap.

Reset
REQ-023 reset=1 at a clock edge SHALL force IDLE, level=0, in_count=out_count=0, n_out=0, m_valid=0, m_last=0, m_data=0, frame_done=0, s_ready=0, config_ready=1 (1 after the reset edge).
REQ-024 Reset mid-frame SHALL discard buffered data; no partial m_last or frame_done is emitted.
REQ-025 total_samples SHALL read 1 after reset (n_out=0).

Verification
REQ-026 Config n=2, s_valid continuous with data 0x0001..0x0004, m_ready=1 -> m_data 1,2,3,4 on consecutive cycles starting one cycle after first accept, m_last only on 0x0004, frame_done one cycle, then config_ready=1.
REQ-027 n=3, DEPTH=2, m_ready=0 for 5 cycles -> level reaches 2, s_ready=0, m_data held at first sample; m_ready=1 then drains all 8 in order, no loss or duplication.
REQ-028 n=0, single sample 0xBEEF -> m_valid with m_last=1, m_data=0xBEEF, frame_done; second s_valid beat not accepted.
REQ-029 Random m_ready/s_valid (50%), n=4, DEPTH=4 -> 16 samples out in order, level never > 4, m_last on 16th only.
REQ-030 Reset asserted after 3 of 8 samples accepted -> all outputs at REQ-023 values next cycle; new config n=1 then yields exactly 2 output samples.
REQ-031 s_valid held high in IDLE for 4 cycles before config -> s_ready=0, level=0, no m_valid.

Source files
------------

// File: rtl/axis_frame_skid_buffer.sv
// -----------------------------------------------------------------------------
// axis_frame_skid_buffer
//
// Frame-sized AXI-Stream buffer. A frame length of 2^config_n samples is
// captured while idle. The block then accepts exactly that many samples on
// the slave port into a small FIFO and forwards them in order on the master
// port. m_last marks the final sample. frame_done pulses once that sample has
// left the block, and the block then returns to idle for the next config.
//
// Ports
//   clk            : single clock, rising edge
//   reset          : synchronous active-high reset
//   s_valid/s_data/s_ready          : AXI-Stream slave (input samples)
//   m_valid/m_data/m_last/m_ready   : AXI-Stream master (output samples)
//   config_n/config_valid/config_ready : frame-size handshake (length = 2^n)
//   n_out          : captured config_n
//   total_samples  : 1 << n_out
//   level          : number of entries currently held
//   frame_done     : one-cycle pulse after the last sample is popped
// -----------------------------------------------------------------------------
module axis_frame_skid_buffer #(
  parameter int SKID_DATA_WIDTH = 16,
  parameter int DEPTH           = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_valid,
  input  logic [SKID_DATA_WIDTH-1:0] s_data,
  output logic                       s_ready,
  output logic                       m_valid,
  output logic [SKID_DATA_WIDTH-1:0] m_data,
  output logic                       m_last,
  input  logic                       m_ready,
  input  logic [3:0]                 config_n,
  input  logic                       config_valid,
  output logic                       config_ready,
  output logic [3:0]                 n_out,
  output logic [15:0]                total_samples,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       frame_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                     r_state;
  logic [SKID_DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]              r_rd_ptr;
  logic [AW-1:0]              r_wr_ptr;
  logic [LW-1:0]              r_level;
  logic [16:0]                r_in_count;
  logic [16:0]                r_out_count;
  logic [3:0]                 r_n;
  logic                       r_frame_done;

  logic [15:0] w_total;
  logic [16:0] w_total_ext;
  logic        w_s_ready;
  logic        w_m_valid;
  logic        w_push;
  logic        w_pop;
  logic        w_last;

  assign w_total     = 16'd1 << r_n;
  assign w_total_ext = {1'b0, w_total};

  // Ready is built only from registered state, so there is no combinational
  // path from m_ready to s_ready; a full buffer never passes data through.
  assign w_s_ready = (r_state == ST_RUN) && (r_level < LW'(DEPTH)) &&
                     (r_in_count < w_total_ext);
  assign w_m_valid = (r_level != {LW{1'b0}});
  assign w_push    = s_valid && w_s_ready;
  assign w_pop     = w_m_valid && m_ready;
  // Head of the FIFO is the sample with index r_out_count.
  assign w_last    = w_m_valid && (r_out_count == (w_total_ext - 17'd1));

  assign s_ready       = w_s_ready;
  assign config_ready  = (r_state == ST_IDLE);
  assign m_valid       = w_m_valid;
  assign m_data        = r_mem[r_rd_ptr];
  assign m_last        = w_last;
  assign n_out         = r_n;
  assign total_samples = w_total;
  assign level         = r_level;
  assign frame_done    = r_frame_done;

  // Frame FSM, FIFO storage, pointers, occupancy and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_rd_ptr     <= {AW{1'b0}};
      r_wr_ptr     <= {AW{1'b0}};
      r_level      <= {LW{1'b0}};
      r_in_count   <= 17'd0;
      r_out_count  <= 17'd0;
      r_n          <= 4'd0;
      r_frame_done <= 1'b0;
      // Clearing storage keeps m_data at zero after reset and drops any
      // partially buffered frame.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {SKID_DATA_WIDTH{1'b0}};
      end
    end else begin
      r_frame_done <= w_pop && w_last;

      if (w_push) begin
        r_mem[r_wr_ptr] <= s_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + AW'(1);
        r_out_count <= r_out_count + 17'd1;
      end

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase

      case (r_state)
        ST_IDLE: begin
          if (config_valid) begin
            r_n         <= config_n;
            r_in_count  <= 17'd0;
            r_out_count <= 17'd0;
            r_state     <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (w_push) begin
            r_in_count <= r_in_count + 17'd1;
            if ((r_in_count + 17'd1) == w_total_ext) begin
              r_state <= ST_DRAIN;
            end else begin
              r_state <= ST_RUN;
            end
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          // The last sample can only leave after every sample was accepted.
          if (w_pop && w_last) begin
            r_in_count  <= 17'd0;
            r_out_count <= 17'd0;
            r_state     <= ST_IDLE;
          end else begin
            r_state <= ST_DRAIN;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_skid_buffer.sv
// -----------------------------------------------------------------------------
// tb_axis_frame_skid_buffer
//
// Self-checking bench for axis_frame_skid_buffer (DEPTH = 2). A behavioural
// model tracks frame state, occupancy and counters. Every accepted sample is
// pushed to a scoreboard queue and compared in order when the master port
// pops it. A table covers the config sizes, and hand-written sequences cover
// stalls, single-sample frames, mid-frame reset and idle-state input.
// -----------------------------------------------------------------------------
module tb_axis_frame_skid_buffer;

  localparam int W     = 16;
  localparam int DEPTH = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic          s_valid;
  logic [W-1:0]  s_data;
  logic          s_ready;
  logic          m_valid;
  logic [W-1:0]  m_data;
  logic          m_last;
  logic          m_ready;
  logic [3:0]    config_n;
  logic          config_valid;
  logic          config_ready;
  logic [3:0]    n_out;
  logic [15:0]   total_samples;
  logic [LW-1:0] level;
  logic          frame_done;

  axis_frame_skid_buffer #(.SKID_DATA_WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .config_n(config_n), .config_valid(config_valid), .config_ready(config_ready),
    .n_out(n_out), .total_samples(total_samples), .level(level),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [W-1:0] sb_q[$];
  int           md_state;   // 0 idle, 1 run, 2 drain
  int           md_level;
  int           md_in;
  int           md_out;
  int           md_total;
  logic         md_done;
  logic [W-1:0] next_data;
  int           pops_in_frame;

  typedef struct {
    logic [3:0]  n;
    logic [15:0] total;
    bit          run;
    bit          rnd;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check the outputs
  // against the model, then advance the model across the rising edge.
  task automatic tick(input bit sv, input bit mr, input bit cv, input logic [3:0] cn);
    bit exp_ready, acc, pop, last;
    s_valid      = sv;
    s_data       = next_data;
    m_ready      = mr;
    config_valid = cv;
    config_n     = cn;
    exp_ready = (md_state == 1) && (md_level < DEPTH) && (md_in < md_total);
    chk("s_ready", s_ready, exp_ready);
    chk("config_ready", config_ready, md_state == 0);
    chk("level", level, md_level);
    chk("m_valid", m_valid, md_level != 0);
    chk("frame_done", frame_done, md_done);
    acc  = sv && exp_ready;
    pop  = mr && (md_level != 0);
    last = 1'b0;
    if (pop) begin
      last = (md_out == md_total - 1);
      chk("m_data", m_data, sb_q[0]);
      chk("m_last", m_last, last);
    end
    @(posedge clk);
    md_done = pop && last;
    if (acc) begin
      sb_q.push_back(next_data);
      next_data = next_data + 16'd1;
      md_in++;
    end
    if (pop) begin
      void'(sb_q.pop_front());
      md_out++;
      pops_in_frame++;
    end
    md_level = md_level + int'(acc) - int'(pop);
    if (md_state == 0 && cv) begin
      md_state = 1;
      md_total = 1 << cn;
      md_in    = 0;
      md_out   = 0;
    end else if (md_state == 1 && acc && md_in == md_total) begin
      md_state = 2;
    end else if (pop && last) begin
      md_state = 0;
      md_in    = 0;
      md_out   = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    s_valid      = 1'b0;
    m_ready      = 1'b0;
    config_valid = 1'b0;
    config_n     = 4'd0;
    reset        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_m_data", m_data, 16'h0000);
    chk("rst_level", level, 0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_config_ready", config_ready, 1'b1);
    chk("rst_n_out", n_out, 4'd0);
    chk("rst_total", total_samples, 16'd1);
    reset = 1'b0;
    sb_q.delete();
    md_state = 0;
    md_level = 0;
    md_in    = 0;
    md_out   = 0;
    md_total = 1;
    md_done  = 1'b0;
  endtask

  task automatic configure(input logic [3:0] cn, input logic [15:0] exp_total);
    tick(1'b0, 1'b0, 1'b1, cn);
    chk("n_out", n_out, cn);
    chk("total_samples", total_samples, exp_total);
    pops_in_frame = 0;
  endtask

  // Stream until the model sees the frame finish, then two idle cycles to
  // see the single frame_done pulse and config_ready return.
  task automatic run_body(input bit rnd, input int budget);
    int cyc = 0;
    while (md_state != 0 && cyc < budget) begin
      if (rnd) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 4'd0);
      else     tick(1'b1, 1'b1, 1'b0, 4'd0);
      cyc++;
    end
    if (md_state != 0) chk("frame_timeout", 32'd1, 32'd0);
    tick(1'b0, 1'b0, 1'b0, 4'd0);
    tick(1'b0, 1'b0, 1'b0, 4'd0);
    chk("frame_len", pops_in_frame, md_total);
  endtask

  initial begin
    logic [W-1:0] first_val;
    int           cyc;

    vecs[0] = '{4'd0,  16'd1,     1'b1, 1'b0};
    vecs[1] = '{4'd2,  16'd4,     1'b1, 1'b0};
    vecs[2] = '{4'd3,  16'd8,     1'b1, 1'b1};
    vecs[3] = '{4'd4,  16'd16,    1'b1, 1'b1};
    vecs[4] = '{4'd5,  16'd32,    1'b1, 1'b1};
    vecs[5] = '{4'd15, 16'd32768, 1'b0, 1'b0};
    vecs[6] = '{4'd1,  16'd2,     1'b1, 1'b0};

    reset        = 1'b1;
    s_valid      = 1'b0;
    s_data       = 16'h0000;
    m_ready      = 1'b0;
    config_valid = 1'b0;
    config_n     = 4'd0;
    next_data    = 16'h0001;
    @(negedge clk);
    do_reset();

    // Table: config sizes, with a full frame where practical.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      configure(vecs[i].n, vecs[i].total);
      if (vecs[i].run) run_body(vecs[i].rnd, 4000);
    end

    // Continuous n=2 frame carrying 1..4; one-cycle latency is checked by
    // the per-cycle m_valid/level comparisons.
    do_reset();
    next_data = 16'h0001;
    configure(4'd2, 16'd4);
    run_body(1'b0, 50);

    // Stall: n=3, m_ready low for 5 cycles fills the buffer and holds data.
    do_reset();
    first_val = next_data;
    configure(4'd3, 16'd8);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0, 4'd0);
    chk("stall_level", level, 2);
    chk("stall_s_ready", s_ready, 1'b0);
    chk("stall_m_data", m_data, first_val);
    run_body(1'b0, 100);

    // Single-sample frame with a second beat offered.
    do_reset();
    next_data = 16'hBEEF;
    configure(4'd0, 16'd1);
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    chk("one_m_data", m_data, 16'hBEEF);
    chk("one_m_last", m_last, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 4'd0);
    run_body(1'b0, 20);

    // Random handshakes, n=4.
    do_reset();
    configure(4'd4, 16'd16);
    run_body(1'b1, 2000);

    // Reset after 3 of 8 samples, then a 2-sample frame.
    do_reset();
    configure(4'd3, 16'd8);
    cyc = 0;
    while (md_in < 3 && cyc < 50) begin
      tick(1'b1, 1'b0, 1'b0, 4'd0);
      if (md_level == DEPTH) tick(1'b0, 1'b1, 1'b0, 4'd0);
      cyc++;
    end
    chk("mid_accepted", md_in, 3);
    do_reset();
    configure(4'd1, 16'd2);
    run_body(1'b1, 500);

    // s_valid in IDLE is ignored.
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 4'd0);
    chk("idle_level", level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
